// File: rtl/ram_bus_master_pkg.sv
// Shared definitions for the RAM bus master: parameter defaults and FSM state encoding.
// IDLE is encoded as zero so a cleared state register is always a legal idle state.
package ram_bus_master_pkg;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_LEN_W      = 4;
  localparam int DEF_RD_LATENCY = 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_WAIT  = 3'd1,
    ST_WR_PULSE = 3'd2,
    ST_RD_PULSE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_RD_RSP   = 3'd5
  } state_e;

endpackage

// File: rtl/ram_burst_addr_gen.sv
// Burst address generator: loadable address register plus remaining-beat down-counter.
// o_last is high while the current beat is the final one of the burst.
module ram_burst_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remain;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_remain <= '0;
    end else if (i_load) begin
      r_addr   <= i_addr;
      r_remain <= i_len;
    end else if (i_step) begin
      // Address wraps naturally at 2**ADDR_W.
      r_addr   <= r_addr + ADDR_W'(1);
      r_remain <= r_remain - LEN_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_remain == '0);

endmodule

// File: rtl/ram_bus_master.sv
// Burst initiator for the on-chip RAM port: converts commands into single-outstanding
// RAM write/read pulses, with a write-data input stream and a read-response output stream.
module ram_bus_master
  import ram_bus_master_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic              clk_system,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              cmd_done,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data
);

  localparam int                LAT_W    = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY);
  localparam logic [LAT_W-1:0]  LAST_LAT = LAT_W'(RD_LATENCY - 1);

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [LAT_W-1:0]  w_lat_cnt_nxt;

  logic              w_load;
  logic              w_step;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last;

  logic              w_cmd_ready_nxt;
  logic              w_wdata_ready_nxt;
  logic              w_rsp_valid_nxt;
  logic [DATA_W-1:0] w_rsp_data_nxt;
  logic              w_rsp_last_nxt;
  logic              w_cmd_done_nxt;
  logic [ADDR_W-1:0] w_ram_rd_addr_nxt;
  logic              w_ram_rd_nxt;
  logic [ADDR_W-1:0] w_ram_wr_addr_nxt;
  logic              w_ram_wr_nxt;
  logic [DATA_W-1:0] w_ram_wr_data_nxt;

  // Reset asserts asynchronously and releases on a clock edge after two flops.
  always_ff @(posedge clk_system or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  ram_burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk    (clk_system),
    .rst_n  (w_rst_n),
    .i_load (w_load),
    .i_step (w_step),
    .i_addr (cmd_addr),
    .i_len  (cmd_len),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_lat_cnt_nxt     = r_lat_cnt;
    w_load            = 1'b0;
    w_step            = 1'b0;
    w_rsp_data_nxt    = rsp_data;
    w_rsp_last_nxt    = rsp_last;
    w_cmd_done_nxt    = 1'b0;
    w_ram_rd_addr_nxt = '0;
    w_ram_rd_nxt      = 1'b0;
    w_ram_wr_addr_nxt = '0;
    w_ram_wr_nxt      = 1'b0;
    w_ram_wr_data_nxt = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          w_load = 1'b1;
          if (cmd_write) begin
            w_state_nxt = ST_WR_WAIT;
          end else begin
            w_state_nxt       = ST_RD_PULSE;
            w_ram_rd_nxt      = 1'b1;
            w_ram_rd_addr_nxt = cmd_addr;
          end
        end
      end

      ST_WR_WAIT: begin
        if (wdata_valid && wdata_ready) begin
          w_state_nxt       = ST_WR_PULSE;
          w_ram_wr_nxt      = 1'b1;
          w_ram_wr_addr_nxt = w_addr;
          w_ram_wr_data_nxt = wdata;
        end
      end

      ST_WR_PULSE: begin
        w_step = 1'b1;
        if (w_last) begin
          w_cmd_done_nxt = 1'b1;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_state_nxt    = ST_WR_WAIT;
        end
      end

      ST_RD_PULSE: begin
        w_state_nxt       = ST_RD_WAIT;
        w_lat_cnt_nxt     = '0;
        w_ram_rd_addr_nxt = w_addr;
      end

      ST_RD_WAIT: begin
        if (r_lat_cnt == LAST_LAT) begin
          w_state_nxt    = ST_RD_RSP;
          w_rsp_data_nxt = ram_rd_data;
          w_rsp_last_nxt = w_last;
        end else begin
          w_lat_cnt_nxt     = r_lat_cnt + LAT_W'(1);
          w_ram_rd_addr_nxt = w_addr;
        end
      end

      ST_RD_RSP: begin
        if (rsp_valid && rsp_ready) begin
          w_step         = 1'b1;
          w_rsp_data_nxt = '0;
          w_rsp_last_nxt = 1'b0;
          if (w_last) begin
            w_cmd_done_nxt = 1'b1;
            w_state_nxt    = ST_IDLE;
          end else begin
            // The generator steps on this same edge, so issue the following address directly.
            w_state_nxt       = ST_RD_PULSE;
            w_ram_rd_nxt      = 1'b1;
            w_ram_rd_addr_nxt = w_addr + ADDR_W'(1);
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    w_cmd_ready_nxt   = (w_state_nxt == ST_IDLE);
    w_wdata_ready_nxt = (w_state_nxt == ST_WR_WAIT);
    w_rsp_valid_nxt   = (w_state_nxt == ST_RD_RSP);
  end

  always_ff @(posedge clk_system or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_lat_cnt   <= '0;
      cmd_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_last    <= 1'b0;
      cmd_done    <= 1'b0;
      ram_rd_addr <= '0;
      ram_rd      <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr      <= 1'b0;
      ram_wr_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_lat_cnt   <= w_lat_cnt_nxt;
      cmd_ready   <= w_cmd_ready_nxt;
      wdata_ready <= w_wdata_ready_nxt;
      rsp_valid   <= w_rsp_valid_nxt;
      rsp_data    <= w_rsp_data_nxt;
      rsp_last    <= w_rsp_last_nxt;
      cmd_done    <= w_cmd_done_nxt;
      ram_rd_addr <= w_ram_rd_addr_nxt;
      ram_rd      <= w_ram_rd_nxt;
      ram_wr_addr <= w_ram_wr_addr_nxt;
      ram_wr      <= w_ram_wr_nxt;
      ram_wr_data <= w_ram_wr_data_nxt;
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// Self-checking bench for ram_bus_master: RAM model, protocol monitor, and a plain-array
// reference memory that predicts every RAM write and every read response.
`timescale 1ns/1ps
module tb_ram_bus_master;

  logic       clk_system = 1'b0;
  logic       reset_n    = 1'b0;
  logic       cmd_valid  = 1'b0;
  logic       cmd_ready;
  logic       cmd_write  = 1'b0;
  logic [7:0] cmd_addr   = '0;
  logic [3:0] cmd_len    = '0;
  logic       wdata_valid = 1'b0;
  logic       wdata_ready;
  logic [7:0] wdata      = '0;
  logic       rsp_valid;
  logic       rsp_ready  = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       cmd_done;
  logic [7:0] ram_rd_addr;
  logic       ram_rd;
  logic [7:0] ram_wr_addr;
  logic       ram_wr;
  logic [7:0] ram_wr_data;
  bit   [7:0] ram_rd_data;

  int total = 0;
  int bad   = 0;

  bit [7:0] mem     [256];
  bit [7:0] ref_mem [256];
  logic [7:0] wbuf  [16];

  logic [7:0] wr_log_a [$];
  logic [7:0] wr_log_d [$];
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int mon_overlap = 0, mon_wide = 0, mon_idle_nz = 0;
  logic prev_wr = 1'b0, prev_rd = 1'b0, prev_done = 1'b0;

  always #25 clk_system = ~clk_system;

  ram_bus_master dut (
    .clk_system  (clk_system),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .cmd_done    (cmd_done),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd      (ram_rd),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr      (ram_wr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_data (ram_rd_data)
  );

  // Synchronous RAM, one-cycle read latency.
  always @(posedge clk_system) begin
    if (ram_wr) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd) ram_rd_data <= mem[ram_rd_addr];
  end

  always @(negedge clk_system) begin
    if (ram_rd && ram_wr) mon_overlap++;
    if (ram_wr && prev_wr) mon_wide++;
    if (ram_rd && prev_rd) mon_wide++;
    if (cmd_done && prev_done) mon_wide++;
    if (!ram_wr && (ram_wr_addr != 8'h00 || ram_wr_data != 8'h00)) mon_idle_nz++;
    if (ram_wr) begin
      wr_log_a.push_back(ram_wr_addr);
      wr_log_d.push_back(ram_wr_data);
      wr_cnt++;
    end
    if (ram_rd) rd_cnt++;
    if (cmd_done) done_cnt++;
    prev_wr   = ram_wr;
    prev_rd   = ram_rd;
    prev_done = cmd_done;
  end

  function automatic logic [7:0] beat_addr(input logic [7:0] a, input int i);
    return 8'(int'(a) + i);
  endfunction

  task automatic wait_cmd_ready(input string name);
    int n = 0;
    @(negedge clk_system);
    while (!cmd_ready && n < 50) begin
      @(negedge clk_system);
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s: cmd_ready=%b required 1 within 50 cycles", name, cmd_ready);
    end
  endtask

  task automatic send_cmd(input bit wr, input logic [7:0] a, input logic [3:0] l);
    int n = 0;
    @(negedge clk_system);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    while (!cmd_ready && n < 100) begin
      @(negedge clk_system);
      n++;
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1 within 100 cycles", cmd_ready);
    end
    @(posedge clk_system); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic write_beat(input logic [7:0] d);
    int n = 0;
    @(negedge clk_system);
    wdata_valid = 1'b1; wdata = d;
    while (!wdata_ready && n < 100) begin
      @(negedge clk_system);
      n++;
    end
    if (!wdata_ready) begin
      total++; bad++;
      $display("FAIL wdata_accept: wdata_ready=%b required 1 within 100 cycles", wdata_ready);
    end
    @(posedge clk_system); #1;
    wdata_valid = 1'b0;
  endtask

  task automatic read_beat(input int stall, output logic [7:0] d, output logic last, output bit stable);
    int n = 0;
    stable = 1'b1;
    @(negedge clk_system);
    while (!rsp_valid && n < 100) begin
      @(negedge clk_system);
      n++;
    end
    if (!rsp_valid) begin
      total++; bad++;
      $display("FAIL rsp_wait: rsp_valid=%b required 1 within 100 cycles", rsp_valid);
    end
    d = rsp_data; last = rsp_last;
    repeat (stall) begin
      @(negedge clk_system);
      if (!rsp_valid || rsp_data !== d || rsp_last !== last) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk_system); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int n = 0;
    while (done_cnt == d0 && n < 20) begin
      @(posedge clk_system); #1;
      n++;
    end
    repeat (3) @(posedge clk_system);
    #1;
    total++;
    if (done_cnt !== d0 + 1) begin
      bad++;
      $display("FAIL %s_done: cmd_done pulses=%0d required 1", name, done_cnt - d0);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [3:0] l, input int stall_beat,
                          input int stall_cyc, input string name);
    int base = wr_log_a.size();
    int d0   = done_cnt;
    int wc;
    bit ok   = 1'b1;
    send_cmd(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      if (i == stall_beat && stall_cyc > 0) begin
        @(posedge clk_system); #1;
        wc = wr_cnt;
        repeat (stall_cyc) @(posedge clk_system);
        #1;
        total++;
        if (wr_cnt !== wc) begin
          bad++;
          $display("FAIL %s_stall: ram_wr pulses during stall=%0d required 0", name, wr_cnt - wc);
        end
      end
      write_beat(wbuf[i]);
      ref_mem[beat_addr(a, i)] = wbuf[i];
    end
    wait_done(d0, name);
    total++;
    if (wr_log_a.size() - base != int'(l) + 1) begin
      ok = 1'b0;
      $display("FAIL %s_wr_count: ram_wr pulses=%0d required %0d", name, wr_log_a.size() - base, int'(l) + 1);
    end else begin
      for (int i = 0; i <= int'(l); i++) begin
        if (wr_log_a[base + i] !== beat_addr(a, i) || wr_log_d[base + i] !== wbuf[i]) begin
          ok = 1'b0;
          $display("FAIL %s_wr_beat%0d: addr/data=%h/%h required %h/%h", name, i,
                   wr_log_a[base + i], wr_log_d[base + i], beat_addr(a, i), wbuf[i]);
        end
      end
    end
    if (!ok) bad++;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [3:0] l, input int stall, input string name);
    int r0 = rd_cnt;
    int d0 = done_cnt;
    logic [7:0] d;
    logic last;
    bit stable;
    send_cmd(1'b0, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      read_beat(stall, d, last, stable);
      total++;
      if (d !== ref_mem[beat_addr(a, i)] || last !== (i == int'(l))) begin
        bad++;
        $display("FAIL %s_rsp%0d: data/last=%h/%b required %h/%b", name, i, d, last,
                 ref_mem[beat_addr(a, i)], (i == int'(l)));
      end
      if (stall > 0) begin
        total++;
        if (!stable) begin
          bad++;
          $display("FAIL %s_stable%0d: rsp changed during stall, required stable", name, i);
        end
      end
    end
    wait_done(d0, name);
    total++;
    if (rd_cnt - r0 !== int'(l) + 1) begin
      bad++;
      $display("FAIL %s_rd_count: ram_rd pulses=%0d required %0d", name, rd_cnt - r0, int'(l) + 1);
    end
  endtask

  task automatic test_reset();
    logic [43:0] outs;
    repeat (3) @(negedge clk_system);
    outs = {cmd_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, cmd_done,
            ram_rd_addr, ram_rd, ram_wr_addr, ram_wr, ram_wr_data};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: outputs=%h required 0", outs);
    end
    reset_n = 1'b1;
    wait_cmd_ready("reset_release");
  endtask

  task automatic test_single();
    wbuf[0] = 8'h72;
    do_write(8'h00, 4'd0, -1, 0, "single_wr");
    do_read(8'h00, 4'd0, 0, "single_rd");
    do_read(8'h01, 4'd0, 0, "unwritten_rd");
    wbuf[0] = 8'hAA;
    do_write(8'h01, 4'd0, -1, 0, "wr_01");
    do_read(8'h01, 4'd0, 0, "rd_01");
  endtask

  task automatic test_wrap();
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    do_write(8'hFE, 4'd3, -1, 0, "wrap_wr");
    total++;
    if (mem[8'hFE] !== 8'h11 || mem[8'hFF] !== 8'h22 || mem[8'h00] !== 8'h33 || mem[8'h01] !== 8'h44) begin
      bad++;
      $display("FAIL wrap_mem: FE..01=%h %h %h %h required 11 22 33 44",
               mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]);
    end
    do_read(8'hFE, 4'd3, 0, "wrap_rd");
  endtask

  task automatic test_rsp_stall();
    do_read(8'hFE, 4'd3, 5, "rsp_stall");
  endtask

  task automatic test_wdata_stall();
    for (int i = 0; i < 4; i++) wbuf[i] = 8'(8'hC0 + i);
    do_write(8'h20, 4'd3, 2, 10, "wdata_stall");
    do_read(8'h20, 4'd3, 0, "wdata_stall_rd");
  endtask

  task automatic test_ignored_inputs();
    int wc = wr_cnt;
    @(negedge clk_system);
    wdata_valid = 1'b1; wdata = 8'h5C; rsp_ready = 1'b1;
    repeat (5) @(negedge clk_system);
    wdata_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk_system);
    total++;
    if (wr_cnt !== wc || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_ignore: ram_wr pulses=%0d cmd_ready=%b required 0/1", wr_cnt - wc, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_burst();
    int base = wr_log_a.size();
    int d0   = done_cnt;
    int n    = 0;
    logic [43:0] outs;
    send_cmd(1'b1, 8'h40, 4'd3);
    write_beat(8'h5A);
    ref_mem[8'h40] = 8'h5A;
    @(negedge clk_system);
    while (!wdata_ready && n < 20) begin
      @(negedge clk_system);
      n++;
    end
    reset_n = 1'b0;
    #1;
    outs = {cmd_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, cmd_done,
            ram_rd_addr, ram_rd, ram_wr_addr, ram_wr, ram_wr_data};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: outputs=%h required 0", outs);
    end
    repeat (3) @(negedge clk_system);
    reset_n = 1'b1;
    wait_cmd_ready("midreset_release");
    repeat (4) @(negedge clk_system);
    total++;
    if (done_cnt !== d0 || wr_log_a.size() - base != 1) begin
      bad++;
      $display("FAIL midreset_activity: cmd_done=%0d ram_wr=%0d required 0/1", done_cnt - d0, wr_log_a.size() - base);
    end
    total++;
    if (mem[8'h40] !== ref_mem[8'h40] || mem[8'h41] !== ref_mem[8'h41] ||
        mem[8'h42] !== ref_mem[8'h42] || mem[8'h43] !== ref_mem[8'h43]) begin
      bad++;
      $display("FAIL midreset_mem: 40..43=%h %h %h %h required %h %h %h %h",
               mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43],
               ref_mem[8'h40], ref_mem[8'h41], ref_mem[8'h42], ref_mem[8'h43]);
    end
    do_read(8'h40, 4'd3, 0, "midreset_rd");
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [3:0] l;
    for (int k = 0; k < 6; k++) begin
      a = 8'($urandom_range(0, 255));
      l = 4'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
      do_write(a, l, int'($urandom_range(0, int'(l))), int'($urandom_range(0, 3)), "rand_wr");
      do_read(a, l, int'($urandom_range(0, 2)), "rand_rd");
    end
  endtask

  task automatic test_monitor();
    total++;
    if (mon_overlap !== 0 || mon_wide !== 0 || mon_idle_nz !== 0) begin
      bad++;
      $display("FAIL monitor: overlap=%0d wide_pulses=%0d idle_nonzero=%0d required 0/0/0",
               mon_overlap, mon_wide, mon_idle_nz);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_rsp_stall();
    test_wdata_stall();
    test_ignored_inputs();
    test_reset_mid_burst();
    test_random();
    test_monitor();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
